// File: rtl/ex_issue_pkg.sv
// ex_issue_pkg -- shared definitions for the EX issue stage.
//   NREG      : default register-file depth
//   RW        : register index width, log2(NREG)
//   DATA_W    : operand width
//   alu_cmd_e : ALU command encodings carried on cmd
package ex_issue_pkg;

    localparam int NREG   = 8;
    localparam int RW     = $clog2(NREG);
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        CMD_ADD = 3'b000,
        CMD_SUB = 3'b001,
        CMD_SHL = 3'b010,
        CMD_GT  = 3'b011,
        CMD_SHR = 3'b100,
        CMD_AND = 3'b101,
        CMD_OR  = 3'b110,
        CMD_EQ  = 3'b111
    } alu_cmd_e;

endpackage

// File: rtl/ex_issue_fwd_mux.sv
// ex_issue_fwd_mux -- per-operand source select for the issue stage.
// Build option: ISSUE_FORWARD_EN adds the EX/MEM and MEM/WB bypass ports
// and selects them ahead of the held register data; without it the operand
// is the held register data only.
// Ports:
//   rs        in  RW     held source index (index 0 reads as zero)
//   reg_data  in  16     held register-file data
//   mem_*     in         EX/MEM producer (ISSUE_FORWARD_EN only)
//   wb_*      in         MEM/WB producer (ISSUE_FORWARD_EN only)
//   op        out 16     selected operand
module ex_issue_fwd_mux #(
    parameter int RW = ex_issue_pkg::RW
) (
    input  logic [RW-1:0] rs,
    input  logic [15:0]   reg_data,
`ifdef ISSUE_FORWARD_EN
    input  logic          mem_wr_en,
    input  logic [RW-1:0] mem_rd,
    input  logic [15:0]   mem_res,
    input  logic          mem_is_load,
    input  logic          wb_wr_en,
    input  logic [RW-1:0] wb_rd,
    input  logic [15:0]   wb_data,
`endif
    output logic [15:0]   op
);
    import ex_issue_pkg::*;

    logic [DATA_W-1:0] sel;

    // A load in EX/MEM has no result yet; the load-use bubble guarantees
    // the consumer picks it up from MEM/WB one cycle later instead.
    always_comb begin
        sel = reg_data;
        if (rs == '0) begin
            sel = '0;
        end
`ifdef ISSUE_FORWARD_EN
        else if (mem_wr_en && !mem_is_load && (mem_rd == rs)) begin
            sel = mem_res;
        end else if (wb_wr_en && (wb_rd == rs)) begin
            sel = wb_data;
        end
`endif
    end

    assign op = sel;

endmodule

// File: rtl/ex_issue.sv
// ex_issue -- ID/EX pipeline register with operand forwarding and hazard
// control, feeding the ALU.
// Build option: ISSUE_FORWARD_EN enables EX/MEM and MEM/WB forwarding (only
// load-use stalls). Without it any RAW dependency on the EX, EX/MEM or
// MEM/WB producer holds the decoded instruction until that producer retires.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid / id_ready        decoded-instruction handshake
//   id_rs1/id_rs2, *_data      source indices and register-file reads
//   id_imm, id_use_imm         immediate and OP2 source select
//   id_cmd, id_rd, id_wr_en,
//   id_is_load                 instruction payload
//   flush                      kill the instruction in the stage
//   ex_stall                   downstream hold
//   mem_*, wb_*                EX/MEM and MEM/WB producers
//   OP1, OP2, cmd              ALU operands and command
//   ex_valid, ex_rd, ex_wr_en,
//   ex_is_load                 issued-instruction status
//   stall_cnt                  saturating count of refused id_valid cycles
module ex_issue #(
    parameter  int NREG = ex_issue_pkg::NREG,
    localparam int RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic [15:0]   id_rs1_data,
    input  logic [15:0]   id_rs2_data,
    input  logic [15:0]   id_imm,
    input  logic          id_use_imm,
    input  logic [2:0]    id_cmd,
    input  logic [RW-1:0] id_rd,
    input  logic          id_wr_en,
    input  logic          id_is_load,
    input  logic          flush,
    input  logic          ex_stall,
    input  logic          mem_wr_en,
    input  logic [RW-1:0] mem_rd,
    input  logic [15:0]   mem_res,
    input  logic          mem_is_load,
    input  logic          wb_wr_en,
    input  logic [RW-1:0] wb_rd,
    input  logic [15:0]   wb_data,
    output logic [15:0]   OP1,
    output logic [15:0]   OP2,
    output logic [2:0]    cmd,
    output logic          ex_valid,
    output logic [RW-1:0] ex_rd,
    output logic          ex_wr_en,
    output logic          ex_is_load,
    output logic [15:0]   stall_cnt
);
    import ex_issue_pkg::*;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // True when a producer writing rd feeds a source the decoded instruction
    // actually reads (rs2 is ignored when OP2 comes from the immediate).
    function automatic logic src_match(input logic [RW-1:0] rd,
                                       input logic [RW-1:0] rs1,
                                       input logic [RW-1:0] rs2,
                                       input logic          use_imm);
        return (rd != '0) && ((rd == rs1) || (!use_imm && (rd == rs2)));
    endfunction

    logic                vld_p1;
    logic                wr_en_p1;
    logic                is_load_p1;
    logic [RW-1:0]       rd_p1;
    logic [RW-1:0]       rs1_p1;
    logic [RW-1:0]       rs2_p1;
    logic [DATA_W-1:0]   rs1_data_p1;
    logic [DATA_W-1:0]   rs2_data_p1;
    logic [DATA_W-1:0]   imm_p1;
    logic                use_imm_p1;
    alu_cmd_e            cmd_p1;
    logic [15:0]         stall_cnt_q;
    logic                hazard;
    logic [DATA_W-1:0]   op1_fwd;
    logic [DATA_W-1:0]   op2_fwd;

    // ID stage: hazard detection and handshake
`ifdef ISSUE_FORWARD_EN
    assign hazard = vld_p1 && is_load_p1 && wr_en_p1 &&
                    src_match(rd_p1, id_rs1, id_rs2, id_use_imm);
`else
    assign hazard = (vld_p1 && wr_en_p1 && src_match(rd_p1, id_rs1, id_rs2, id_use_imm)) ||
                    (mem_wr_en && src_match(mem_rd, id_rs1, id_rs2, id_use_imm)) ||
                    (wb_wr_en && src_match(wb_rd, id_rs1, id_rs2, id_use_imm));

    // Producer data and load flag only matter when bypassing.
    logic unused_nofwd;
    assign unused_nofwd = ^{mem_res, wb_data, mem_is_load};
`endif

    assign id_ready = !ex_stall && !hazard;

    // ID/EX boundary: flush beats stall, stall beats capture; a refused or
    // absent instruction becomes a bubble with its side effects cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            wr_en_p1    <= 1'b0;
            is_load_p1  <= 1'b0;
            rd_p1       <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            imm_p1      <= '0;
            use_imm_p1  <= 1'b0;
            cmd_p1      <= CMD_ADD;
        end else if (flush) begin
            vld_p1     <= 1'b0;
            wr_en_p1   <= 1'b0;
            is_load_p1 <= 1'b0;
        end else if (!ex_stall) begin
            if (id_valid && id_ready) begin
                vld_p1      <= 1'b1;
                wr_en_p1    <= id_wr_en;
                is_load_p1  <= id_is_load;
                rd_p1       <= id_rd;
                rs1_p1      <= id_rs1;
                rs2_p1      <= id_rs2;
                rs1_data_p1 <= id_rs1_data;
                rs2_data_p1 <= id_rs2_data;
                imm_p1      <= id_imm;
                use_imm_p1  <= id_use_imm;
                cmd_p1      <= alu_cmd_e'(id_cmd);
            end else begin
                vld_p1     <= 1'b0;
                wr_en_p1   <= 1'b0;
                is_load_p1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (id_valid && !id_ready) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    // EX stage: operand selection toward the ALU
    ex_issue_fwd_mux #(.RW(RW)) u_fwd_mux_op1 (
        .rs          (rs1_p1),
        .reg_data    (rs1_data_p1),
`ifdef ISSUE_FORWARD_EN
        .mem_wr_en   (mem_wr_en),
        .mem_rd      (mem_rd),
        .mem_res     (mem_res),
        .mem_is_load (mem_is_load),
        .wb_wr_en    (wb_wr_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
`endif
        .op          (op1_fwd)
    );

    ex_issue_fwd_mux #(.RW(RW)) u_fwd_mux_op2 (
        .rs          (rs2_p1),
        .reg_data    (rs2_data_p1),
`ifdef ISSUE_FORWARD_EN
        .mem_wr_en   (mem_wr_en),
        .mem_rd      (mem_rd),
        .mem_res     (mem_res),
        .mem_is_load (mem_is_load),
        .wb_wr_en    (wb_wr_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
`endif
        .op          (op2_fwd)
    );

    assign OP1        = op1_fwd;
    assign OP2        = use_imm_p1 ? imm_p1 : op2_fwd;
    assign cmd        = cmd_p1;
    assign ex_valid   = vld_p1;
    assign ex_rd      = rd_p1;
    assign ex_wr_en   = wr_en_p1;
    assign ex_is_load = is_load_p1;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_ex_issue.sv
module tb_ex_issue;

    typedef struct {
        logic        idv;
        logic [2:0]  rs1, rs2, rd, cmd;
        logic [15:0] d1, d2, imm;
        logic        ui, wr, ld, fl, st;
        logic        mwr, mld, wwr;
        logic [2:0]  mrd, wrd;
        logic [15:0] mres, wdat;
        logic        e_rdy, e_vld, e_wr, e_ld, chk_op;
        logic [15:0] e_op1, e_op2, e_cnt;
        logic [2:0]  e_cmd;
    } vec_t;

    typedef struct {
        logic        v, wr, ld, ui;
        logic [2:0]  rd, rs1, rs2, cmd;
        logic [15:0] d1, d2, imm;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_ready;
    logic [2:0]  id_rs1, id_rs2, id_rd, id_cmd;
    logic [15:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_use_imm, id_wr_en, id_is_load;
    logic        flush, ex_stall;
    logic        mem_wr_en, mem_is_load, wb_wr_en;
    logic [2:0]  mem_rd, wb_rd;
    logic [15:0] mem_res, wb_data;
    logic [15:0] OP1, OP2, stall_cnt;
    logic [2:0]  cmd, ex_rd;
    logic        ex_valid, ex_wr_en, ex_is_load;

    int n_vec = 0;
    int n_err = 0;

    vec_t  tbl[10];
    vec_t  v;
    slot_t m;
    logic [15:0] m_cnt;
    logic  rdy;

    always #5 clk = ~clk;

    ex_issue #(.NREG(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_cmd(id_cmd),
        .id_rd(id_rd), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
        .flush(flush), .ex_stall(ex_stall),
        .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_res(mem_res), .mem_is_load(mem_is_load),
        .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .OP1(OP1), .OP2(OP2), .cmd(cmd),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t a);
        id_valid = a.idv;   id_rs1 = a.rs1;      id_rs2 = a.rs2;
        id_rs1_data = a.d1; id_rs2_data = a.d2;  id_imm = a.imm;
        id_use_imm = a.ui;  id_cmd = a.cmd;      id_rd = a.rd;
        id_wr_en = a.wr;    id_is_load = a.ld;
        flush = a.fl;       ex_stall = a.st;
        mem_wr_en = a.mwr;  mem_rd = a.mrd;      mem_res = a.mres; mem_is_load = a.mld;
        wb_wr_en = a.wwr;   wb_rd = a.wrd;       wb_data = a.wdat;
    endtask

    // Reference rules: which register the decoded instruction really reads,
    // which producers it must wait for, and where each operand comes from.
    function automatic logic reads_reg(input logic [2:0] r, input vec_t a);
        return (r != 3'd0) && ((r == a.rs1) || (!a.ui && (r == a.rs2)));
    endfunction

    function automatic logic exp_ready(input slot_t s, input vec_t a);
        logic [2:0] waits[$];
        if (a.st) return 1'b0;
`ifdef ISSUE_FORWARD_EN
        if (s.v && s.wr && s.ld) waits.push_back(s.rd);
`else
        if (s.v && s.wr) waits.push_back(s.rd);
        if (a.mwr)       waits.push_back(a.mrd);
        if (a.wwr)       waits.push_back(a.wrd);
`endif
        foreach (waits[i]) if (reads_reg(waits[i], a)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [15:0] exp_opnd(input logic [2:0] rs, input logic [15:0] held, input vec_t a);
        if (rs == 3'd0) return 16'd0;
`ifdef ISSUE_FORWARD_EN
        if (a.mwr && !a.mld && a.mrd == rs) return a.mres;
        if (a.wwr && a.wrd == rs) return a.wdat;
`endif
        return held;
    endfunction

    function automatic slot_t next_slot(input slot_t s, input vec_t a, input logic r);
        slot_t n = s;
        if (a.fl || (!a.st && !(a.idv && r))) begin
            n.v = 1'b0; n.wr = 1'b0; n.ld = 1'b0;
        end else if (!a.st) begin
            n.v = 1'b1; n.rd = a.rd; n.wr = a.wr; n.ld = a.ld;
            n.rs1 = a.rs1; n.rs2 = a.rs2; n.d1 = a.d1; n.d2 = a.d2;
            n.imm = a.imm; n.ui = a.ui; n.cmd = a.cmd;
        end
        return n;
    endfunction

    function automatic vec_t rand_vec();
        vec_t r = '{default: '0};
        r.idv  = ($urandom_range(9, 0) < 7);
        r.rs1  = 3'($urandom_range(7, 0));
        r.rs2  = 3'($urandom_range(7, 0));
        r.rd   = 3'($urandom_range(7, 0));
        r.cmd  = 3'($urandom_range(7, 0));
        r.d1   = 16'($urandom);
        r.d2   = 16'($urandom);
        r.imm  = 16'($urandom);
        r.ui   = ($urandom_range(3, 0) == 0);
        r.wr   = ($urandom_range(3, 0) != 0);
        r.ld   = ($urandom_range(2, 0) == 0);
        r.st   = ($urandom_range(9, 0) < 2);
        r.fl   = ($urandom_range(14, 0) == 0);
        r.mwr  = ($urandom_range(1, 0) == 0);
        r.mrd  = 3'($urandom_range(7, 0));
        r.mres = 16'($urandom);
        r.mld  = ($urandom_range(3, 0) == 0);
        r.wwr  = ($urandom_range(1, 0) == 0);
        r.wrd  = 3'($urandom_range(7, 0));
        r.wdat = 16'($urandom);
        return r;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ex_valid"},   ex_valid,   1'b0);
        chk({tag, "_ex_wr_en"},   ex_wr_en,   1'b0);
        chk({tag, "_ex_is_load"}, ex_is_load, 1'b0);
        chk({tag, "_ex_rd"},      ex_rd,      3'd0);
        chk({tag, "_cmd"},        cmd,        3'd0);
        chk({tag, "_OP1"},        OP1,        16'd0);
        chk({tag, "_OP2"},        OP2,        16'd0);
        chk({tag, "_stall_cnt"},  stall_cnt,  16'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed sequence; state carries from one row to the next.
        tbl[0] = '{idv:1, rs1:2, d1:16'd5, rs2:3, d2:16'd7, cmd:0, rd:1, wr:1,
                   e_rdy:1, e_vld:1, e_wr:1, chk_op:1, e_op1:16'd5, e_op2:16'd7, e_cmd:0, e_cnt:0, default:'0};
        tbl[1] = '{idv:1, rs1:5, d1:16'd10, rs2:1, d2:16'h9999, imm:16'd3, ui:1, cmd:1, rd:4, wr:1,
                   e_rdy:1, e_vld:1, e_wr:1, chk_op:1, e_op1:16'd10, e_op2:16'd3, e_cmd:1, e_cnt:0, default:'0};
        tbl[2] = '{idv:1, rs1:0, d1:16'h1234, rs2:0, d2:16'h5678, cmd:7, mwr:1, mrd:0, mres:16'hFFFF,
                   e_rdy:1, e_vld:1, chk_op:1, e_op1:16'd0, e_op2:16'd0, e_cmd:7, e_cnt:0, default:'0};
        tbl[3] = '{idv:1, st:1, rs1:6, d1:16'hAAAA, cmd:2, rd:2, wr:1,
                   e_rdy:0, e_vld:1, chk_op:1, e_op1:16'd0, e_op2:16'd0, e_cmd:7, e_cnt:1, default:'0};
        tbl[4] = '{idv:1, st:1, fl:1, rs1:6, d1:16'hAAAA, cmd:2, rd:2, wr:1,
                   e_rdy:0, e_vld:0, e_cnt:2, default:'0};
        tbl[5] = '{idv:1, rs1:6, d1:16'h0F0F, rs2:7, d2:16'h00FF, cmd:5, rd:3, wr:1, ld:1,
                   e_rdy:1, e_vld:1, e_wr:1, e_ld:1, chk_op:1, e_op1:16'h0F0F, e_op2:16'h00FF, e_cmd:5, e_cnt:2, default:'0};
        tbl[6] = '{idv:1, rs1:3, d1:16'h1234, rs2:0, cmd:0, rd:5, wr:1, ld:1,
                   e_rdy:0, e_vld:0, e_cnt:3, default:'0};
        tbl[7] = '{idv:1, rs1:3, d1:16'h1234, rs2:0, cmd:0, rd:5, wr:1, ld:1,
                   e_rdy:1, e_vld:1, e_wr:1, e_ld:1, chk_op:1, e_op1:16'h1234, e_op2:16'd0, e_cmd:0, e_cnt:3, default:'0};
        tbl[8] = '{idv:1, rs1:1, d1:16'h0101, rs2:5, d2:16'hBEEF, imm:16'h0042, ui:1, cmd:6, rd:0, wr:1, ld:1,
                   e_rdy:1, e_vld:1, e_wr:1, e_ld:1, chk_op:1, e_op1:16'h0101, e_op2:16'h0042, e_cmd:6, e_cnt:3, default:'0};
        tbl[9] = '{idv:1, rs1:0, d1:16'd7, rs2:0, d2:16'd8, cmd:3, rd:2,
                   e_rdy:1, e_vld:1, chk_op:1, e_op1:16'd0, e_op2:16'd0, e_cmd:3, e_cnt:3, default:'0};

        // Power-on reset
        rst_n = 1'b0;
        v = '{default: '0};
        apply(v);
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        #1;
        chk("por_id_ready", id_ready, 1'b1);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            apply(tbl[i]);
            #1;
            chk($sformatf("t%0d_id_ready", i), id_ready, tbl[i].e_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("t%0d_ex_valid", i),   ex_valid,   tbl[i].e_vld);
            chk($sformatf("t%0d_ex_wr_en", i),   ex_wr_en,   tbl[i].e_wr);
            chk($sformatf("t%0d_ex_is_load", i), ex_is_load, tbl[i].e_ld);
            chk($sformatf("t%0d_stall_cnt", i),  stall_cnt,  tbl[i].e_cnt);
            if (tbl[i].chk_op) begin
                chk($sformatf("t%0d_OP1", i), OP1, tbl[i].e_op1);
                chk($sformatf("t%0d_OP2", i), OP2, tbl[i].e_op2);
                chk($sformatf("t%0d_cmd", i), cmd, tbl[i].e_cmd);
            end
        end

        // Hold under ex_stall until stall_cnt reaches 9, then reset between edges.
        v = '{idv:1, st:1, rs1:4, d1:16'h4444, cmd:1, rd:1, wr:1, default:'0};
        repeat (6) begin
            @(negedge clk);
            apply(v);
        end
        @(negedge clk);
        #1;
        chk("hold_stall_cnt", stall_cnt, 16'd9);
        chk("hold_ex_valid",  ex_valid,  1'b1);
        chk("hold_cmd",       cmd,       3'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async");

        @(negedge clk);
        rst_n = 1'b1;
        v = '{idv:1, rs1:2, d1:16'h0077, rs2:3, d2:16'h0088, cmd:4, rd:6, wr:1, default:'0};
        apply(v);
        #1;
        chk("resume_id_ready", id_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("resume_ex_valid",  ex_valid,  1'b1);
        chk("resume_OP1",       OP1,       16'h0077);
        chk("resume_OP2",       OP2,       16'h0088);
        chk("resume_cmd",       cmd,       3'd4);
        chk("resume_stall_cnt", stall_cnt, 16'd0);

        // Slot holds rs1=2 (0x0077), rs2=3 (0x0088); ex_stall keeps it in place.
`ifdef ISSUE_FORWARD_EN
        @(negedge clk);
        v = '{st:1, mwr:1, mrd:2, mres:16'h00AA, wwr:1, wrd:2, wdat:16'h0055, default:'0};
        apply(v);
        #1;
        chk("fwd_mem_OP1", OP1, 16'h00AA);
        chk("fwd_mem_OP2", OP2, 16'h0088);
        @(negedge clk);
        v.mld = 1'b1;
        apply(v);
        #1;
        chk("fwd_memload_OP1", OP1, 16'h0055);
        @(negedge clk);
        v.mwr = 1'b0; v.mld = 1'b0; v.wrd = 3'd3;
        apply(v);
        #1;
        chk("fwd_wb_OP1", OP1, 16'h0077);
        chk("fwd_wb_OP2", OP2, 16'h0055);
`else
        @(negedge clk);
        v = '{st:1, mwr:1, mrd:2, mres:16'h00AA, wwr:1, wrd:3, wdat:16'h0055, default:'0};
        apply(v);
        #1;
        chk("nofwd_OP1", OP1, 16'h0077);
        chk("nofwd_OP2", OP2, 16'h0088);
        @(negedge clk);
        v = '{idv:1, rs1:2, wwr:1, wrd:2, default:'0};
        apply(v);
        #1;
        chk("nofwd_wb_raw_ready", id_ready, 1'b0);
        @(negedge clk);
        v = '{idv:1, rs1:5, rs2:2, mwr:1, mrd:2, default:'0};
        apply(v);
        #1;
        chk("nofwd_mem_raw_ready", id_ready, 1'b0);
        @(negedge clk);
        v = '{idv:1, rs1:5, rs2:2, ui:1, mwr:1, mrd:2, default:'0};
        apply(v);
        #1;
        chk("nofwd_imm_noraw_ready", id_ready, 1'b1);
`endif

        // Randomized run against the reference rules, from a clean reset.
        @(negedge clk);
        rst_n = 1'b0;
        v = '{default: '0};
        apply(v);
        @(negedge clk);
        rst_n = 1'b1;
        m = '{default: '0};
        m_cnt = 16'd0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            v = rand_vec();
            apply(v);
            #1;
            rdy = exp_ready(m, v);
            chk("rnd_id_ready",   id_ready,   rdy);
            chk("rnd_ex_valid",   ex_valid,   m.v);
            chk("rnd_ex_wr_en",   ex_wr_en,   m.wr);
            chk("rnd_ex_is_load", ex_is_load, m.ld);
            chk("rnd_stall_cnt",  stall_cnt,  m_cnt);
            if (m.v) begin
                chk("rnd_ex_rd", ex_rd, m.rd);
                chk("rnd_cmd",   cmd,   m.cmd);
                chk("rnd_OP1",   OP1,   exp_opnd(m.rs1, m.d1, v));
                chk("rnd_OP2",   OP2,   m.ui ? m.imm : exp_opnd(m.rs2, m.d2, v));
            end
            @(posedge clk);
            m = next_slot(m, v, rdy);
            if (v.idv && !rdy && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
